// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-chip-select, bit-serial SPI master clocked by the system clock.
// Frames: IDLE -> CMD -> {WDATA | TURN -> RDATA} -> GAP -> IDLE, MSB first.
// Optional feature: define PARITY_EN to add an even-parity bit after each data word.
// Handshake: a command is taken on any rising edge where data_in_valid && ready;
// ready is high only in IDLE, and valid while ready is low is ignored (no queueing).
module spi_master_mc #(
  parameter int NUM_CS    = 2,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 32,
  localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W+ADDR_W+1:0] Data_in,
  input  logic                     data_in_valid,
  input  logic [CSW-1:0]           CS_Sel,
  output logic                     ready,
  output logic                     MOSI,
  input  logic                     MISO,
  output logic [NUM_CS-1:0]        CS,
  output logic [DATA_W-1:0]        Data_out,
  output logic                     data_out_valid,
  output logic                     parity_err,
  output logic [2:0]               dbg_state
);

  localparam int FRAME_W = DATA_W + ADDR_W + 2;
  localparam int CMD_LEN = ADDR_W + 2;
`ifdef PARITY_EN
  localparam int WORD_LEN = DATA_W + 1;
`else
  localparam int WORD_LEN = DATA_W;
`endif
  localparam int CNT_MAX = (CMD_LEN > WORD_LEN) ? CMD_LEN : WORD_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0]        MODE_RD_INC = 2'b01;
  localparam logic [1:0]        MODE_BCAST  = 2'b11;
  localparam logic [DATA_W-1:0] ONE_WORD    = DATA_W'(1);
  localparam logic [DATA_W-1:0] MAX_N       = DATA_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_TURN, S_RDATA, S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        in_mode;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              accept, drop;
  logic [DATA_W-1:0] burst_n;

  logic [FRAME_W-1:0] tx_sh;
  logic               is_wr_q, bcast_q;
  logic [CSW-1:0]     sel_q;
  logic [DATA_W-1:0]  words_left;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  rx_sh;
  logic               cmd_end, word_end, cs_active;
`ifdef PARITY_EN
  logic               tx_par;
`endif

  assign in_mode   = Data_in[1:0];
  assign in_addr   = Data_in[ADDR_W+1:2];
  assign in_data   = Data_in[FRAME_W-1:ADDR_W+2];
  assign accept    = data_in_valid && (state_q == S_IDLE);
  assign drop      = (int'(CS_Sel) >= NUM_CS) && (in_mode != MODE_BCAST);
  assign cmd_end   = (bit_cnt == CNT_W'(CMD_LEN - 1));
  assign word_end  = (bit_cnt == CNT_W'(WORD_LEN - 1));
  assign cs_active = (state_q == S_CMD) || (state_q == S_WDATA) ||
                     (state_q == S_TURN) || (state_q == S_RDATA);
  assign ready     = (state_q == S_IDLE);
  assign dbg_state = state_q;

  // Word count for the accepted command: 1 for everything except RD_INC, which is clipped to 1..MAX_BURST.
  always_comb begin
    burst_n = ONE_WORD;
    if (in_mode == MODE_RD_INC) begin
      if (in_data == '0)        burst_n = ONE_WORD;
      else if (in_data > MAX_N) burst_n = MAX_N;
      else                      burst_n = in_data;
    end
  end

  // State register; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a dropped command (bad CS_Sel) goes straight to the single GAP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (data_in_valid) state_d = drop ? S_GAP : S_CMD;
      S_CMD:   if (cmd_end) state_d = is_wr_q ? S_WDATA : S_TURN;
      S_WDATA: if (word_end) state_d = S_GAP;
      S_TURN:  state_d = S_RDATA;
      S_RDATA: if (word_end && (words_left == ONE_WORD)) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serial outputs: MOSI carries mode/addr then write data; CS low only while a frame is on the wire.
  always_comb begin
    MOSI = 1'b0;
    CS   = '1;
    case (state_q)
      S_CMD:   MOSI = tx_sh[FRAME_W-1];
`ifdef PARITY_EN
      S_WDATA: MOSI = word_end ? tx_par : tx_sh[FRAME_W-1];
`else
      S_WDATA: MOSI = tx_sh[FRAME_W-1];
`endif
      default: MOSI = 1'b0;
    endcase
    if (cs_active) begin
      if (bcast_q) CS = '0;
      else         CS[sel_q] = 1'b0;
    end
  end

  // Datapath: command capture, TX shifting, bit/word counting and RX word assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sh          <= '0;
      is_wr_q        <= 1'b0;
      bcast_q        <= 1'b0;
      sel_q          <= '0;
      words_left     <= '0;
      bit_cnt        <= '0;
      rx_sh          <= '0;
      Data_out       <= '0;
      data_out_valid <= 1'b0;
`ifdef PARITY_EN
      tx_par         <= 1'b0;
      parity_err     <= 1'b0;
`endif
    end else begin
      data_out_valid <= 1'b0;
`ifdef PARITY_EN
      parity_err     <= 1'b0;
`endif
      if (accept) begin
        tx_sh      <= {in_mode, in_addr, in_data};
        is_wr_q    <= in_mode[1];
        bcast_q    <= (in_mode == MODE_BCAST);
        sel_q      <= CS_Sel;
        words_left <= burst_n;
`ifdef PARITY_EN
        tx_par     <= ^in_data;
`endif
      end
      if ((state_q == S_CMD) || (state_q == S_WDATA)) tx_sh <= tx_sh << 1;

      if (state_d != state_q)                     bit_cnt <= '0;
      else if ((state_q == S_RDATA) && word_end)  bit_cnt <= '0;
      else if ((state_q == S_CMD) || (state_q == S_WDATA) || (state_q == S_RDATA))
        bit_cnt <= bit_cnt + 1'b1;
      else                                        bit_cnt <= '0;

      if (state_q == S_RDATA) begin
`ifdef PARITY_EN
        // Last cycle of a word is the slave's parity bit; the word is delivered with its check.
        if (word_end) begin
          Data_out       <= rx_sh;
          data_out_valid <= 1'b1;
          parity_err     <= ((^rx_sh) != MISO);
          words_left     <= words_left - 1'b1;
        end else begin
          rx_sh <= {rx_sh[DATA_W-2:0], MISO};
        end
`else
        rx_sh <= {rx_sh[DATA_W-2:0], MISO};
        if (word_end) begin
          Data_out       <= {rx_sh[DATA_W-2:0], MISO};
          data_out_valid <= 1'b1;
          words_left     <= words_left - 1'b1;
        end
`endif
      end
    end
  end

`ifndef PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
